// File: rtl/ccc_apb_cfg_master.sv
// APB3 replay engine for the FCCC dynamic-reconfiguration port with PLL reset/lock sequencing.
// Define CCC_CFG_READBACK_EN to verify every write with an APB read-back cycle.

module ccc_apb_cfg_master #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       PCLK,
    input  logic       RESET,
    input  logic       CFG_VALID,
    output logic       CFG_READY,
    input  logic [5:0] CFG_ADDR,
    input  logic [7:0] CFG_DATA,
    input  logic       CFG_LAST,
    output logic       ENG_BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [5:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       CCC_BUSY,
    input  logic       LOCK,
    output logic       PLL_ARST_N
);

    localparam logic [CNT_W-1:0] RstLast  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StWSetup, StWAccess, StRSetup, StRAccess, StNext, StRstHold, StLockWait
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             arst_n_q, arst_n_d;
    logic             drop_q, drop_d;
    logic             lock_s1_q, lock_s2_q;
    logic             accept;

    always_comb begin
        CFG_READY  = ~RESET & ~CCC_BUSY & ((state_q == StIdle) | (state_q == StNext));
        PSEL       = (state_q == StWSetup) | (state_q == StWAccess) |
                     (state_q == StRSetup) | (state_q == StRAccess);
        PENABLE    = (state_q == StWAccess) | (state_q == StRAccess);
        PWRITE     = (state_q == StWSetup) | (state_q == StWAccess);
        PADDR      = addr_q;
        PWDATA     = data_q;
        ENG_BUSY   = busy_q;
        DONE       = done_q;
        ERR        = err_q;
        ERR_CODE   = err_code_q;
        PLL_ARST_N = arst_n_q;
    end

    always_comb begin
        accept     = CFG_VALID & CFG_READY;
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        cnt_d      = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        arst_n_d   = arst_n_q;
        drop_d     = drop_q;

        case (state_q)
            StIdle, StNext: begin
                if (accept) begin
                    // Leftovers of a burst aborted by a read-back error are swallowed.
                    if (drop_q) begin
                        drop_d = ~CFG_LAST;
                    end else begin
                        addr_d  = CFG_ADDR;
                        data_d  = CFG_DATA;
                        last_d  = CFG_LAST;
                        state_d = StWSetup;
                        if (state_q == StIdle) begin
                            busy_d     = 1'b1;
                            err_code_d = 2'd0;
                            arst_n_d   = 1'b0;
                        end
                    end
                end
            end
            StWSetup: state_d = StWAccess;
            StWAccess: begin
`ifdef CCC_CFG_READBACK_EN
                state_d = StRSetup;
`else
                state_d = last_q ? StRstHold : StNext;
`endif
            end
`ifdef CCC_CFG_READBACK_EN
            StRSetup: state_d = StRAccess;
            StRAccess: begin
                if (PRDATA != data_q) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    arst_n_d   = 1'b1;
                    busy_d     = 1'b0;
                    drop_d     = ~last_q;
                    state_d    = StIdle;
                end else begin
                    state_d = last_q ? StRstHold : StNext;
                end
            end
`endif
            StRstHold: begin
                if (cnt_q == RstLast) begin
                    arst_n_d = 1'b1;
                    state_d  = StLockWait;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StLockWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == LockLast) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            arst_n_q   <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            arst_n_q   <= arst_n_d;
            drop_q     <= drop_d;
        end
    end

    // Synchroniser is held clear while the PLL is in reset so a stale lock cannot leak through.
    always_ff @(posedge PCLK) begin
        if (RESET || !arst_n_q) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= LOCK;
            lock_s2_q <= lock_s1_q;
        end
    end

`ifndef CCC_CFG_READBACK_EN
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;
`endif

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Scoreboard bench for ccc_apb_cfg_master: expected APB transfers and DONE/ERR events are queued
// by the stimulus and consumed by a negedge monitor.

module tb_ccc_apb_cfg_master;

    localparam int unsigned RST_CYC = 16;
    localparam int unsigned TMO     = 100;
`ifdef CCC_CFG_READBACK_EN
    localparam int          XFER    = 4;
    localparam int          PAT_LEN = 15;
    localparam logic [14:0] PAT_EXP = 15'b111101111011110;
`else
    localparam int          XFER    = 2;
    localparam int          PAT_LEN = 9;
    localparam logic [14:0] PAT_EXP = 15'b000000110110110;
`endif

    logic       PCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CFG_VALID = 1'b0;
    logic       CFG_READY;
    logic [5:0] CFG_ADDR = '0;
    logic [7:0] CFG_DATA = '0;
    logic       CFG_LAST = 1'b0;
    logic       ENG_BUSY, DONE, ERR;
    logic [1:0] ERR_CODE;
    logic       PSEL, PENABLE, PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       CCC_BUSY = 1'b0;
    logic       LOCK = 1'b0;
    logic       PLL_ARST_N;

    logic       bad = 1'b0;
    logic [7:0] mem [0:63];

    typedef struct packed { logic wr; logic [5:0] addr; logic [7:0] data; } apb_t;
    typedef struct packed { logic is_err; logic [1:0] code; } evt_t;
    apb_t apb_q[$];
    evt_t evt_q[$];
    apb_t mon_a;
    evt_t mon_e;

    int checks = 0;
    int errors = 0;

    ccc_apb_cfg_master #(
        .PLL_RST_CYCLES(RST_CYC),
        .LOCK_TIMEOUT  (TMO),
        .CNT_W         (17)
    ) dut (
        .PCLK      (PCLK),
        .RESET     (RESET),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_DATA  (CFG_DATA),
        .CFG_LAST  (CFG_LAST),
        .ENG_BUSY  (ENG_BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .CCC_BUSY  (CCC_BUSY),
        .LOCK      (LOCK),
        .PLL_ARST_N(PLL_ARST_N)
    );

    always #5 PCLK = ~PCLK;

    // Simple CCC register file; bad forces a corrupted read-back.
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    always @(posedge PCLK) if (PSEL && PENABLE && PWRITE) mem[PADDR] <= PWDATA;
    assign PRDATA = bad ? 8'hFF : mem[PADDR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (!RESET) begin
            if (PSEL && PENABLE) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected: got addr=0x%0h wr=%0b, required no transfer",
                             PADDR, PWRITE);
                end else begin
                    mon_a = apb_q.pop_front();
                    chk("apb_pwrite", 32'(PWRITE), 32'(mon_a.wr));
                    chk("apb_paddr", 32'(PADDR), 32'(mon_a.addr));
                    chk("apb_pwdata", 32'(PWDATA), 32'(mon_a.data));
                end
            end
            if (DONE || ERR) begin
                if (evt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected: got done=%0b err=%0b, required none", DONE, ERR);
                end else begin
                    mon_e = evt_q.pop_front();
                    chk("evt_err", 32'(ERR), 32'(mon_e.is_err));
                    chk("evt_done", 32'(DONE), 32'(!mon_e.is_err));
                    chk("evt_code", 32'(ERR_CODE), 32'(mon_e.code));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_cfg_ready", 32'(CFG_READY), 0);
        chk("rst_eng_busy", 32'(ENG_BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_err_code", 32'(ERR_CODE), 0);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_pll_arst_n", 32'(PLL_ARST_N), 1);
    endtask

    // Present one entry at a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [5:0] a, input logic [7:0] d, input logic last,
                        input logic xfer);
        CFG_VALID = 1'b1;
        CFG_ADDR  = a;
        CFG_DATA  = d;
        CFG_LAST  = last;
        if (xfer) begin
            apb_q.push_back('{1'b1, a, d});
`ifdef CCC_CFG_READBACK_EN
            apb_q.push_back('{1'b0, a, d});
`endif
        end
        for (int i = 0; i < 100 && !CFG_READY; i++) @(negedge PCLK);
        chk("host_accept", 32'(CFG_READY), 1);
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic wait_evt();
        for (int i = 0; i < 300 && !(DONE || ERR); i++) @(negedge PCLK);
        chk("evt_seen", 32'(DONE || ERR), 1);
    endtask

    task automatic wait_release();
        for (int i = 0; i < 300 && !PLL_ARST_N; i++) @(negedge PCLK);
        chk("pll_release", 32'(PLL_ARST_N), 1);
    endtask

    task automatic finish_done();
        wait_release();
        evt_q.push_back('{1'b0, 2'd0});
        LOCK = 1'b1;
        wait_evt();
        @(negedge PCLK);
        LOCK = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int           k;
        logic [14:0]  pat;
        logic         flag;

        repeat (3) @(negedge PCLK);
        check_reset_outputs();
        RESET = 1'b0;
        @(negedge PCLK);

        // Single entry; LOCK rises two negedges after release -> DONE five negedges after release.
        send(6'h1A, 8'h5C, 1'b1, 1'b1);
        CFG_VALID = 1'b0;
        k = 0;
        while (!PLL_ARST_N && k < 1000) begin
            k++;
            @(negedge PCLK);
        end
        chk("pll_low_cycles", 32'(k), 32'(XFER + RST_CYC));
        chk("busy_in_lock_wait", 32'(ENG_BUSY), 1);
        repeat (2) @(negedge PCLK);
        LOCK = 1'b1;
        evt_q.push_back('{1'b0, 2'd0});
        k = 2;
        while (!DONE && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        chk("done_latency", 32'(k), 5);
        chk("busy_after_done", 32'(ENG_BUSY), 0);
        @(negedge PCLK);
        chk("done_one_cycle", 32'(DONE), 0);
        LOCK = 1'b0;
        chk("single_xfer_only", 32'(apb_q.size()), 0);

        // Three-entry burst with CFG_VALID continuous.
        pat  = '0;
        flag = 1'b0;
        fork
            begin
                send(6'h01, 8'h11, 1'b0, 1'b1);
                send(6'h02, 8'h22, 1'b0, 1'b1);
                send(6'h03, 8'h33, 1'b1, 1'b1);
                CFG_VALID = 1'b0;
            end
            begin
                for (int i = 0; i < 20 && !PSEL; i++) @(negedge PCLK);
                for (int i = 0; i < PAT_LEN; i++) begin
                    pat  = {pat[13:0], PSEL};
                    flag = flag | PLL_ARST_N;
                    @(negedge PCLK);
                end
            end
        join
        chk("burst_psel_pattern", 32'(pat), 32'(PAT_EXP));
        chk("burst_single_reset_window", 32'(flag), 0);
        finish_done();

        // CCC_BUSY blocks acceptance for 10 cycles.
        CCC_BUSY  = 1'b1;
        CFG_VALID = 1'b1;
        CFG_ADDR  = 6'h05;
        CFG_DATA  = 8'hA5;
        CFG_LAST  = 1'b1;
        apb_q.push_back('{1'b1, 6'h05, 8'hA5});
`ifdef CCC_CFG_READBACK_EN
        apb_q.push_back('{1'b0, 6'h05, 8'hA5});
`endif
        #1;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            flag = flag | CFG_READY | PSEL;
            @(negedge PCLK);
        end
        chk("busy_blocks", 32'(flag), 0);
        CCC_BUSY = 1'b0;
        #1;
        chk("ready_after_busy", 32'(CFG_READY), 1);
        @(posedge PCLK);
        @(negedge PCLK);
        CFG_VALID = 1'b0;
        chk("setup_after_busy", 32'(PSEL && !PENABLE), 1);
        finish_done();

        // Lock timeout: ERR exactly TMO cycles after LOCK_WAIT entry (= release edge).
        evt_q.push_back('{1'b1, 2'd2});
        send(6'h0C, 8'h3E, 1'b1, 1'b1);
        CFG_VALID = 1'b0;
        wait_release();
        k = 0;
        while (!ERR && k < 300) begin
            @(negedge PCLK);
            k++;
        end
        chk("timeout_latency", 32'(k), 32'(TMO));
        chk("timeout_busy", 32'(ENG_BUSY), 0);
        @(negedge PCLK);
        chk("err_one_cycle", 32'(ERR), 0);
        chk("err_code_held", 32'(ERR_CODE), 2);

`ifdef CCC_CFG_READBACK_EN
        // Read-back mismatch aborts, rest of burst is swallowed.
        bad = 1'b1;
        evt_q.push_back('{1'b1, 2'd1});
        send(6'h22, 8'h5C, 1'b0, 1'b1);
        CFG_VALID = 1'b0;
        for (int i = 0; i < 20 && !ERR; i++) @(negedge PCLK);
        chk("rb_err", 32'(ERR), 1);
        chk("rb_pll_released", 32'(PLL_ARST_N), 1);
        chk("rb_busy", 32'(ENG_BUSY), 0);
        @(negedge PCLK);
        bad = 1'b0;
        send(6'h23, 8'h01, 1'b0, 1'b0);
        send(6'h24, 8'h02, 1'b1, 1'b0);
        CFG_VALID = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("rb_drop_idle", 32'(ENG_BUSY), 0);
        chk("rb_code_held", 32'(ERR_CODE), 1);
`endif

        // Reset during W_ACCESS of entry 2.
        send(6'h30, 8'h11, 1'b0, 1'b1);
        chk("err_code_cleared", 32'(ERR_CODE), 0);
        send(6'h31, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !(PENABLE && PWRITE); i++) @(negedge PCLK);
        chk("e2_waccess", 32'(PENABLE && PWRITE), 1);
        #1;
        RESET     = 1'b1;
        CFG_VALID = 1'b0;
        @(negedge PCLK);
        check_reset_outputs();
`ifdef CCC_CFG_READBACK_EN
        apb_q.delete();
`endif
        RESET = 1'b0;
        flag  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            flag = flag | DONE | ERR | PSEL | !PLL_ARST_N;
        end
        chk("post_reset_quiet", 32'(flag), 0);

        chk("apb_queue_drained", 32'(apb_q.size()), 0);
        chk("evt_queue_drained", 32'(evt_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
